// File: rtl/weight_loader_m_axi_fifo_prog.sv
// weight_loader_m_axi_fifo_prog
// Synchronous FWFT FIFO for the weight_loader m_axi channels. It has a
// prefetching output register, clk_en gating, almost-full/almost-empty
// thresholds, a synchronous flush and an exact occupancy count.
// Build option: define WEIGHT_LOADER_FIFO_ERR_FLAGS_EN to enable the sticky
// overflow/underflow detectors. Without it, both ports are tied to 0.
// Data path (DEPTH>=2): storage (registered read) -> prefetch stage -> output
// register. A word written at edge t therefore appears on if_dout after edge t+2.
module weight_loader_m_axi_fifo_prog #(
  parameter              MEM_STYLE     = "block",
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned ADDR_WIDTH    = 6,
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned AFULL_THRESH  = DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  output logic                  if_full_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  full_n_reg;
  logic                  afull_reg;
  logic                  aempty_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic                  push;
  logic                  accept;
  logic                  clear;

  // A flush behaves like a reset, but only when the FIFO is enabled.
  assign clear  = reset | (clk_en & flush);
  assign push   = clk_en & ~flush & if_write & full_n_reg;
  assign accept = clk_en & if_read & out_valid_reg;

  // Occupancy changes only when exactly one side of the handshake fires.
  always_comb begin
    count_next = count_reg;
    case ({push, accept})
      2'b10:   count_next = count_reg + (ADDR_WIDTH+1)'(1);
      2'b01:   count_next = count_reg - (ADDR_WIDTH+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // The count and all status flags are registered from next-count, so they update together.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg  <= '0;
      full_n_reg <= 1'b1;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
    end else if (clk_en) begin
      count_reg  <= count_next;
      full_n_reg <= (count_next != DEPTH_C);
      afull_reg  <= (count_next >= AFULL_C);
      aempty_reg <= (count_next <= AEMPTY_C);
    end
  end

  assign if_full_n         = full_n_reg;
  assign if_empty_n        = out_valid_reg;
  assign if_dout           = dout_reg;
  assign if_num_data_valid = count_reg;
  assign almost_full       = afull_reg;
  assign almost_empty      = aempty_reg;

  generate
    if (DEPTH == 1) begin : g_reg_only
      // With a single entry, the output register is the whole FIFO, so a push loads it directly.
      always_ff @(posedge clk) begin
        if (clear) begin
          out_valid_reg <= 1'b0;
        end else if (clk_en) begin
          if (push)
            out_valid_reg <= 1'b1;
          else if (accept)
            out_valid_reg <= 1'b0;
        end
      end

      // Output data capture; its contents are meaningless while empty.
      always_ff @(posedge clk) begin
        if (push)
          dout_reg <= if_din;
      end
    end else begin : g_storage
      logic [ADDR_WIDTH:0]   mem_cnt_reg;
      logic                  q_valid_reg;
      logic [DATA_WIDTH-1:0] q_data_reg;
      logic                  pop;
      logic                  q_move;

      // Prefetch: the stage ahead moves forward whenever the stage behind is free or is being drained.
      assign q_move = clk_en & q_valid_reg & (~out_valid_reg | accept);
      assign pop    = clk_en & (mem_cnt_reg != '0) & (~q_valid_reg | q_move);

      if (MEM_STYLE == "shiftreg") begin : g_shiftreg
        logic [DATA_WIDTH-1:0] sr [0:DEPTH-2];
        logic [ADDR_WIDTH-1:0] rd_idx;

        // The oldest word sits at index mem_cnt-1.
        assign rd_idx = mem_cnt_reg[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

        for (genvar gi = 0; gi < DEPTH - 1; gi++) begin : g_tap
          if (gi == 0) begin : g_head
            // New words enter at tap 0.
            always_ff @(posedge clk) begin
              if (push)
                sr[gi] <= if_din;
            end
          end else begin : g_body
            // Each push shifts every tap one place deeper.
            always_ff @(posedge clk) begin
              if (push)
                sr[gi] <= sr[gi-1];
            end
          end
        end

        // Registered read of the oldest word into the prefetch stage.
        always_ff @(posedge clk) begin
          if (pop)
            q_data_reg <= sr[rd_idx];
        end
      end else begin : g_ram
        localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 2);
        logic [DATA_WIDTH-1:0] mem [0:DEPTH-2];
        logic [ADDR_WIDTH-1:0] wptr_reg;
        logic [ADDR_WIDTH-1:0] rptr_reg;

        // Circular pointers wrap modulo DEPTH-1, because the output register holds the last entry.
        always_ff @(posedge clk) begin
          if (clear) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
          end else begin
            if (push)
              wptr_reg <= (wptr_reg == LAST_PTR) ? '0 : wptr_reg + ADDR_WIDTH'(1);
            if (pop)
              rptr_reg <= (rptr_reg == LAST_PTR) ? '0 : rptr_reg + ADDR_WIDTH'(1);
          end
        end

        // RAM write port.
        always_ff @(posedge clk) begin
          if (push)
            mem[wptr_reg] <= if_din;
        end

        // RAM registered read port; it only reads words written on an earlier edge.
        always_ff @(posedge clk) begin
          if (pop)
            q_data_reg <= mem[rptr_reg];
        end
      end

      // Occupancy of the storage, plus the valid bits of the two prefetch stages.
      always_ff @(posedge clk) begin
        if (clear) begin
          mem_cnt_reg   <= '0;
          q_valid_reg   <= 1'b0;
          out_valid_reg <= 1'b0;
        end else if (clk_en) begin
          mem_cnt_reg   <= mem_cnt_reg + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
          q_valid_reg   <= pop | (q_valid_reg & ~q_move);
          out_valid_reg <= q_move | (out_valid_reg & ~accept);
        end
      end

      // Output register loads from the prefetch stage.
      always_ff @(posedge clk) begin
        if (q_move)
          dout_reg <= q_data_reg;
      end
    end
  endgenerate

`ifdef WEIGHT_LOADER_FIFO_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  // Sticky detectors for rejected writes and rejected reads; a flush clears them.
  always_ff @(posedge clk) begin
    if (clear) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clk_en) begin
      if (if_write & ~full_n_reg)
        overflow_reg <= 1'b1;
      if (if_read & ~out_valid_reg)
        underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
